// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the decode-stage hazard scoreboard.
// Optional feature macro: WB_BYPASS_EN (write-through regfile bypass).
package hazard_scoreboard_pkg;

  // Maximum writers in flight per register; counters saturate here.
  localparam int PIPE_DEPTH = 3;
  localparam int CNT_W      = $clog2(PIPE_DEPTH + 1);

  // R0-R7 plus the condition codes, which live in the last slot.
  localparam int SB_NUM    = 9;
  localparam int SB_CC_IDX = 8;

  typedef logic [2:0]       lc3b_reg;
  typedef logic [CNT_W-1:0] lc3b_sb_cnt;

  localparam lc3b_sb_cnt SB_CNT_MAX  = lc3b_sb_cnt'(PIPE_DEPTH);
  localparam lc3b_sb_cnt SB_CNT_ONE  = lc3b_sb_cnt'(1);
  localparam lc3b_sb_cnt SB_CNT_ZERO = lc3b_sb_cnt'(0);

endpackage

// File: rtl/hazard_scoreboard_sb_counter.sv
// Saturating up/down in-flight writer counter for one scoreboard slot.
// Raises a one-cycle error strobe on increment at full or decrement at zero,
// in which case the count holds. With WB_BYPASS_EN defined, a slot whose last
// writer is retiring this cycle is reported as not pending.
module sb_counter
  import hazard_scoreboard_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic pending,
  output logic busy_next,
  output logic err
);

  lc3b_sb_cnt cnt_q;
  lc3b_sb_cnt cnt_d;

  // Next count: simultaneous inc and dec cancel; out-of-range moves hold and flag.
  always_comb begin
    cnt_d = cnt_q;
    err   = 1'b0;
    if (inc && !dec) begin
      if (cnt_q == SB_CNT_MAX) begin
        err = 1'b1;
      end else begin
        cnt_d = cnt_q + SB_CNT_ONE;
      end
    end else if (dec && !inc) begin
      if (cnt_q == SB_CNT_ZERO) begin
        err = 1'b1;
      end else begin
        cnt_d = cnt_q - SB_CNT_ONE;
      end
    end
  end

  // Pending view seen by the hazard compare in decode.
  always_comb begin
`ifdef WB_BYPASS_EN
    pending = (cnt_q != SB_CNT_ZERO) && !((cnt_q == SB_CNT_ONE) && dec);
`else
    pending = (cnt_q != SB_CNT_ZERO);
`endif
    busy_next = (cnt_d != SB_CNT_ZERO);
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= SB_CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage issue controller: tracks in-flight writers for R0-R7 and CC,
// stalls decode on a RAW hazard, and reports busy / sticky error status.
// Optional feature macro: WB_BYPASS_EN (same-cycle writeback bypass).
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    dec_valid,
  input  lc3b_reg dec_sr1,
  input  logic    dec_sr1_used,
  input  lc3b_reg dec_sr2,
  input  logic    dec_sr2_used,
  input  logic    dec_cc_used,
  input  lc3b_reg dec_dest,
  input  logic    dec_writes,
  input  logic    dec_cc_writes,
  input  logic    pipe_freeze,
  input  logic    wb_retire,
  input  lc3b_reg wb_reg,
  input  logic    wb_reg_wr,
  input  logic    wb_cc_wr,
  output logic    hazard_stall,
  output logic    issue,
  output logic    sb_busy,
  output logic    sb_error
);

  logic [SB_NUM-1:0] inc_vec;
  logic [SB_NUM-1:0] dec_vec;
  logic [SB_NUM-1:0] pending_vec;
  logic [SB_NUM-1:0] busy_next_vec;
  logic [SB_NUM-1:0] err_vec;
  logic              raw_hit;

  logic sb_busy_q;
  logic sb_busy_d;
  logic sb_error_q;
  logic sb_error_d;

  // Retire decode from writeback: one decrement strobe per slot.
  always_comb begin
    dec_vec = '0;
    for (int r = 0; r < 8; r++) begin
      dec_vec[r] = wb_retire && wb_reg_wr && (wb_reg == lc3b_reg'(r));
    end
    dec_vec[SB_CC_IDX] = wb_retire && wb_cc_wr;
  end

  // RAW compare against pending writers; both outputs forced low in reset.
  always_comb begin
    raw_hit = (dec_sr1_used && pending_vec[dec_sr1]) ||
              (dec_sr2_used && pending_vec[dec_sr2]) ||
              (dec_cc_used  && pending_vec[SB_CC_IDX]);
    hazard_stall = !reset && dec_valid && raw_hit;
    issue        = !reset && dec_valid && !hazard_stall && !pipe_freeze;
  end

  // Issue decode: only an instruction that actually leaves decode increments.
  always_comb begin
    inc_vec = '0;
    for (int r = 0; r < 8; r++) begin
      inc_vec[r] = issue && dec_writes && (dec_dest == lc3b_reg'(r));
    end
    inc_vec[SB_CC_IDX] = issue && dec_cc_writes;
  end

  for (genvar g = 0; g < SB_NUM; g++) begin : g_slot
    sb_counter u_cnt (
      .clk       (clk),
      .reset     (reset),
      .inc       (inc_vec[g]),
      .dec       (dec_vec[g]),
      .pending   (pending_vec[g]),
      .busy_next (busy_next_vec[g]),
      .err       (err_vec[g])
    );
  end

  // Status next-state: busy mirrors the post-edge counts, error is sticky.
  always_comb begin
    sb_busy_d  = |busy_next_vec;
    sb_error_d = sb_error_q || (|err_vec);
  end

  // Status registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_busy_q  <= 1'b0;
      sb_error_q <= 1'b0;
    end else begin
      sb_busy_q  <= sb_busy_d;
      sb_error_q <= sb_error_d;
    end
  end

  assign sb_busy  = sb_busy_q;
  assign sb_error = sb_error_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard; expectations come from a
// behavioural reference model and are queued per driven cycle.
// Optional feature macro: WB_BYPASS_EN (changes the expected release cycle).
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  logic    clk;
  logic    reset;
  logic    dec_valid;
  lc3b_reg dec_sr1;
  logic    dec_sr1_used;
  lc3b_reg dec_sr2;
  logic    dec_sr2_used;
  logic    dec_cc_used;
  lc3b_reg dec_dest;
  logic    dec_writes;
  logic    dec_cc_writes;
  logic    pipe_freeze;
  logic    wb_retire;
  lc3b_reg wb_reg;
  logic    wb_reg_wr;
  logic    wb_cc_wr;
  logic    hazard_stall;
  logic    issue;
  logic    sb_busy;
  logic    sb_error;

  typedef struct packed {
    logic    valid;
    lc3b_reg sr1;
    logic    sr1_used;
    lc3b_reg sr2;
    logic    sr2_used;
    logic    cc_used;
    lc3b_reg dest;
    logic    writes;
    logic    cc_writes;
    logic    freeze;
    logic    retire;
    lc3b_reg wreg;
    logic    wreg_wr;
    logic    wcc_wr;
  } stim_t;

  int checks = 0;
  int passes = 0;

  // Reference model state.
  int mcnt [SB_NUM];
  bit merr;
  bit last_issue;

  // Scoreboard: {exp_stall, exp_issue, obs_stall, obs_issue, exp_busy, exp_err}.
  logic [5:0] exp_q [$];
  string      tag_q [$];

  hazard_scoreboard dut (
    .clk           (clk),
    .reset         (reset),
    .dec_valid     (dec_valid),
    .dec_sr1       (dec_sr1),
    .dec_sr1_used  (dec_sr1_used),
    .dec_sr2       (dec_sr2),
    .dec_sr2_used  (dec_sr2_used),
    .dec_cc_used   (dec_cc_used),
    .dec_dest      (dec_dest),
    .dec_writes    (dec_writes),
    .dec_cc_writes (dec_cc_writes),
    .pipe_freeze   (pipe_freeze),
    .wb_retire     (wb_retire),
    .wb_reg        (wb_reg),
    .wb_reg_wr     (wb_reg_wr),
    .wb_cc_wr      (wb_cc_wr),
    .hazard_stall  (hazard_stall),
    .issue         (issue),
    .sb_busy       (sb_busy),
    .sb_error      (sb_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %b, expected %b", tag, obs, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t writer(input lc3b_reg d);
    stim_t s;
    s = '0;
    s.valid  = 1'b1;
    s.dest   = d;
    s.writes = 1'b1;
    return s;
  endfunction

  function automatic stim_t reader(input lc3b_reg r);
    stim_t s;
    s = '0;
    s.valid    = 1'b1;
    s.sr1      = r;
    s.sr1_used = 1'b1;
    return s;
  endfunction

  function automatic stim_t addRetire(input stim_t base, input lc3b_reg r, input logic rw,
                                      input logic cw);
    stim_t s;
    s         = base;
    s.retire  = 1'b1;
    s.wreg    = r;
    s.wreg_wr = rw;
    s.wcc_wr  = cw;
    return s;
  endfunction

  task automatic modelReset();
    for (int r = 0; r < SB_NUM; r++) mcnt[r] = 0;
    merr = 1'b0;
  endtask

  // Reference model: expected combinational outputs, then the post-edge state.
  task automatic modelStep(output logic e_hs, output logic e_iss, output logic e_busy,
                           output logic e_err);
    bit pend [SB_NUM];
    bit incv [SB_NUM];
    bit decv [SB_NUM];
    bit any;
    for (int r = 0; r < SB_NUM; r++) begin
      if (r == SB_CC_IDX) decv[r] = wb_retire && wb_cc_wr;
      else                decv[r] = wb_retire && wb_reg_wr && (int'(wb_reg) == r);
      pend[r] = (mcnt[r] != 0);
`ifdef WB_BYPASS_EN
      if (mcnt[r] == 1 && decv[r]) pend[r] = 1'b0;
`endif
    end
    e_hs  = dec_valid && ((dec_sr1_used && pend[dec_sr1]) ||
                          (dec_sr2_used && pend[dec_sr2]) ||
                          (dec_cc_used  && pend[SB_CC_IDX]));
    e_iss = dec_valid && !e_hs && !pipe_freeze;
    any   = 1'b0;
    for (int r = 0; r < SB_NUM; r++) begin
      if (r == SB_CC_IDX) incv[r] = e_iss && dec_cc_writes;
      else                incv[r] = e_iss && dec_writes && (int'(dec_dest) == r);
      if (incv[r] && !decv[r]) begin
        if (mcnt[r] == PIPE_DEPTH) merr = 1'b1;
        else                       mcnt[r]++;
      end else if (decv[r] && !incv[r]) begin
        if (mcnt[r] == 0) merr = 1'b1;
        else              mcnt[r]--;
      end
      if (mcnt[r] != 0) any = 1'b1;
    end
    e_busy = any;
    e_err  = merr;
  endtask

  task automatic driveInputs(input stim_t s);
    dec_valid     = s.valid;
    dec_sr1       = s.sr1;
    dec_sr1_used  = s.sr1_used;
    dec_sr2       = s.sr2;
    dec_sr2_used  = s.sr2_used;
    dec_cc_used   = s.cc_used;
    dec_dest      = s.dest;
    dec_writes    = s.writes;
    dec_cc_writes = s.cc_writes;
    pipe_freeze   = s.freeze;
    wb_retire     = s.retire;
    wb_reg        = s.wreg;
    wb_reg_wr     = s.wreg_wr;
    wb_cc_wr      = s.wcc_wr;
  endtask

  // Drive one cycle of stimulus and queue its expected results.
  task automatic applyStimulus(input string tag, input stim_t s);
    logic e_hs, e_iss, e_busy, e_err;
    @(negedge clk);
    driveInputs(s);
    modelStep(e_hs, e_iss, e_busy, e_err);
    last_issue = e_iss;
    #2;
    exp_q.push_back({e_hs, e_iss, hazard_stall, issue, e_busy, e_err});
    tag_q.push_back(tag);
  endtask

  // Output side: after each active edge, retire one queued entry.
  always @(posedge clk) begin
    logic [5:0] ent;
    string      t;
    #1;
    if (exp_q.size() != 0) begin
      ent = exp_q.pop_front();
      t   = tag_q.pop_front();
      checkOutput({t, "_stall"}, ent[3], ent[5]);
      checkOutput({t, "_issue"}, ent[2], ent[4]);
      checkOutput({t, "_busy"},  sb_busy, ent[1]);
      checkOutput({t, "_err"},   sb_error, ent[0]);
    end
  end

  task automatic waitDrain();
    int budget;
    budget = 10;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      #2;
      budget--;
    end
    if (exp_q.size() != 0) checkOutput("drain_timeout", 1'b0, 1'b1);
  endtask

  // Re-present a stalled instruction until the model says it issues.
  task automatic holdUntilIssue(input string tag, input stim_t s);
    int budget;
    budget = 6;
    while (!last_issue && budget > 0) begin
      applyStimulus(tag, s);
      budget--;
    end
    if (!last_issue) checkOutput({tag, "_timeout"}, 1'b0, 1'b1);
  endtask

  initial begin
    stim_t s;
    modelReset();
    last_issue = 1'b0;

    // Power-on reset with a valid reader presented.
    reset = 1'b1;
    driveInputs(reader(3'd0));
    #1;
    checkOutput("por_stall", hazard_stall, 1'b0);
    checkOutput("por_issue", issue, 1'b0);
    checkOutput("por_busy",  sb_busy, 1'b0);
    checkOutput("por_err",   sb_error, 1'b0);
    @(negedge clk);
    driveInputs(idle());
    reset = 1'b0;

    // RAW on R1 released by its retire.
    s = writer(3'd1);
    s.cc_writes = 1'b1;
    applyStimulus("t2_add_r1", s);
    s = writer(3'd2);
    s.cc_writes = 1'b1;
    s.sr1 = 3'd1; s.sr1_used = 1'b1;
    s.sr2 = 3'd4; s.sr2_used = 1'b1;
    applyStimulus("t2_stall_a", s);
    applyStimulus("t2_stall_b", s);
    applyStimulus("t2_retire", addRetire(s, 3'd1, 1'b1, 1'b1));
    holdUntilIssue("t2_release", s);
    applyStimulus("t2_drain", addRetire(idle(), 3'd2, 1'b1, 1'b1));

    // WAW: two writers to R5, reader released only after both retire.
    applyStimulus("t3_w1", writer(3'd5));
    applyStimulus("t3_w2", writer(3'd5));
    applyStimulus("t3_ret1", addRetire(reader(3'd5), 3'd5, 1'b1, 1'b0));
    applyStimulus("t3_still", reader(3'd5));
    applyStimulus("t3_ret2", addRetire(reader(3'd5), 3'd5, 1'b1, 1'b0));
    applyStimulus("t3_free", reader(3'd5));

    // Same-edge issue and retire of R6.
    applyStimulus("t4_w", writer(3'd6));
    applyStimulus("t4_same", addRetire(writer(3'd6), 3'd6, 1'b1, 1'b0));
    applyStimulus("t4_chk", reader(3'd6));
    applyStimulus("t4_drain", addRetire(idle(), 3'd6, 1'b1, 1'b0));

    // Overflow on R0: count must saturate at the pipe depth.
    repeat (PIPE_DEPTH + 1) applyStimulus("t5_over", writer(3'd0));
    applyStimulus("t5_r0_ret1", addRetire(idle(), 3'd0, 1'b1, 1'b0));
    applyStimulus("t5_r0_ret2", addRetire(idle(), 3'd0, 1'b1, 1'b0));
    applyStimulus("t5_r0_cnt1", reader(3'd0));
    applyStimulus("t5_r0_ret3", addRetire(idle(), 3'd0, 1'b1, 1'b0));
    applyStimulus("t5_r0_free", reader(3'd0));

    // Mid-run reset with R3 holding two writers.
    applyStimulus("t1_w1", writer(3'd3));
    applyStimulus("t1_w2", writer(3'd3));
    applyStimulus("t1_pend", reader(3'd3));
    waitDrain();
    @(negedge clk);
    driveInputs(reader(3'd3));
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("t1_rst_stall", hazard_stall, 1'b0);
    checkOutput("t1_rst_issue", issue, 1'b0);
    checkOutput("t1_rst_busy",  sb_busy, 1'b0);
    checkOutput("t1_rst_err",   sb_error, 1'b0);
    @(negedge clk);
    driveInputs(idle());
    reset = 1'b0;
    applyStimulus("t1_after", reader(3'd3));

    // Underflow on R2: sticky error, count stays at zero.
    applyStimulus("t5_under", addRetire(idle(), 3'd2, 1'b1, 1'b0));
    applyStimulus("t5_cnt0", reader(3'd2));

    // Freeze blocks issue and increments.
    s = writer(3'd7);
    s.sr1 = 3'd7; s.sr1_used = 1'b1;
    s.freeze = 1'b1;
    applyStimulus("t6_frz", s);
    applyStimulus("t6_r7", reader(3'd7));

    // CC dependency: BR waits for the CC writer to retire.
    s = idle();
    s.valid = 1'b1; s.cc_writes = 1'b1;
    applyStimulus("t6_add", s);
    s = idle();
    s.valid = 1'b1; s.cc_used = 1'b1;
    applyStimulus("t6_br_a", s);
    applyStimulus("t6_br_b", s);
    applyStimulus("t6_brret", addRetire(s, 3'd0, 1'b0, 1'b1));
    holdUntilIssue("t6_br_rel", s);
    applyStimulus("t6_end", idle());

    waitDrain();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
